// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide engine that owns the architectural HI/LO
//   registers. MULT/MULTU use a shift-add loop and DIV/DIVU use a restoring
//   shift-subtract loop. Both work on operand magnitudes; the sign fix is
//   applied in one extra cycle before HI/LO are written.
//   MTHI/MTLO write HI/LO directly from IDLE, so they complete in one cycle.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   start  : issue an op; sampled only while idle
//   op     : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//            11x no-op
//   srca   : multiplicand / dividend / MTHI-MTLO source
//   srcb   : multiplier / divisor
//   abort  : squash the in-flight op (no HI/LO write, no done)
//   busy   : op in flight; HI/LO not yet valid
//   done   : one-cycle pulse after a mul/div has written HI/LO
//   hi, lo : architectural HI and LO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT stateReg, stateNext;

  logic [CW-1:0]    countReg;
  logic             isDivReg;
  logic             negAReg;     // dividend sign; the remainder takes this sign
  logic             negResReg;   // operand signs differ; negate product/quotient
  logic [WIDTH-1:0] magAReg;
  logic [WIDTH-1:0] magBReg;
  logic [WIDTH-1:0] accHiReg;    // mul: running upper half; div: partial remainder
  logic [WIDTH-1:0] accLoReg;    // mul: multiplier/lower product; div: dividend/quotient
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             doneReg;

  // Issue decode
  logic             accept;
  logic             opSigned;
  logic             srcaNeg;
  logic             srcbNeg;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  assign accept   = (stateReg == IDLE) && start && !abort;
  assign opSigned = ~op[0];
  assign srcaNeg  = opSigned & srca[WIDTH-1];
  assign srcbNeg  = opSigned & srcb[WIDTH-1];
  // The magnitude of the most-negative value wraps to 2^(WIDTH-1).
  // Read as unsigned, that is the correct magnitude.
  assign magA     = srcaNeg ? -srca : srca;
  assign magB     = srcbNeg ? -srcb : srcb;

  // Datapath step logic
  // The sum is one bit wider, so the carry survives the right shift.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divGe;
  logic [WIDTH-1:0] divRem;

  assign mulSum   = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, magAReg} : '0);
  assign divShift = {accHiReg, accLoReg[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, magBReg};
  // When divGe is set, the difference is below the divisor and fits in WIDTH bits.
  assign divRem   = divShift[WIDTH-1:0] - magBReg;

  // Sign correction, valid during FIX
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  always_comb begin
    prodMag = {accHiReg, accLoReg};
    prodFix = negResReg ? -prodMag : prodMag;
    resHi   = prodFix[2*WIDTH-1:WIDTH];
    resLo   = prodFix[WIDTH-1:0];
    if (isDivReg) begin
      if (magBReg == '0) begin
        // Divide by zero returns the original dividend in HI and all ones in LO.
        resHi = negAReg ? -magAReg : magAReg;
        resLo = '1;
      end else begin
        resLo = negResReg ? -accLoReg : accLoReg;
        resHi = negAReg   ? -accHiReg : accHiReg;
      end
    end
  end

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (accept && !op[2]) stateNext = RUN;
      RUN: begin
        if (abort)                     stateNext = IDLE;
        else if (countReg == CW'(1))   stateNext = FIX;
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countReg  <= '0;
      isDivReg  <= 1'b0;
      negAReg   <= 1'b0;
      negResReg <= 1'b0;
      magAReg   <= '0;
      magBReg   <= '0;
      accHiReg  <= '0;
      accLoReg  <= '0;
      hiReg     <= '0;
      loReg     <= '0;
      doneReg   <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (accept) begin
            case (op)
              3'b100: hiReg <= srca;
              3'b101: loReg <= srca;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                isDivReg  <= op[1];
                negAReg   <= srcaNeg;
                negResReg <= srcaNeg ^ srcbNeg;
                magAReg   <= magA;
                magBReg   <= magB;
                accHiReg  <= '0;
                accLoReg  <= op[1] ? magA : magB;
                countReg  <= CW'(WIDTH);
              end
              default: ;  // reserved ops are ignored
            endcase
          end
        end
        RUN: begin
          if (!abort) begin
            if (isDivReg) begin
              // Restoring step: shift in the next dividend bit, then subtract if it fits.
              accHiReg <= divGe ? divRem : divShift[WIDTH-1:0];
              accLoReg <= {accLoReg[WIDTH-2:0], divGe};
            end else begin
              // Shift-add step: add the multiplicand when the multiplier LSB is set, then shift right.
              accHiReg <= mulSum[WIDTH:1];
              accLoReg <= {mulSum[0], accLoReg[WIDTH-1:1]};
            end
            countReg <= countReg - CW'(1);
          end
        end
        FIX: begin
          if (!abort) begin
            hiReg   <= resHi;
            loReg   <= resLo;
            doneReg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (stateReg != IDLE);
  assign done = doneReg;
  assign hi   = hiReg;
  assign lo   = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH = 32).
// Table-driven mul/div vectors plus hand-written sequences for reset,
// abort, MTHI/MTLO and ignored issue.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_RSVD  = 3'b110;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int compared   = 0;
  int mismatched = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vecT;

  vecT vecs[13];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Issue one mul/div and follow it to completion.
  // If injectAt != 0, a stray start (DIVU 100/7) is driven on that busy
  // cycle; it must be ignored.
  task automatic runOp(input string name, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                       input int injectAt);
    logic [W-1:0] hiBefore;
    logic [W-1:0] loBefore;
    int  cycles;
    bit  doneWhileBusy;
    bit  holdBad;
    cycles = 0;
    doneWhileBusy = 1'b0;
    holdBad = 1'b0;
    @(negedge clk);
    hiBefore = hi;
    loBefore = lo;
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; op = OP_RSVD; srca = 32'hDEADBEEF; srcb = 32'h0;
    while (busy && cycles < 100) begin
      cycles++;
      if (done) doneWhileBusy = 1'b1;
      if (hi !== hiBefore || lo !== loBefore) holdBad = 1'b1;
      if (injectAt != 0 && cycles == injectAt) begin
        start = 1'b1; op = OP_DIVU; srca = 32'd100; srcb = 32'd7;
      end else begin
        start = 1'b0; op = OP_RSVD;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, " busyCycles"}, 32'(cycles), 32'd33);
    check({name, " doneWhileBusy"}, {31'b0, doneWhileBusy}, 32'd0);
    check({name, " hiloHeld"}, {31'b0, holdBad}, 32'd0);
    check({name, " done"}, {31'b0, done}, 32'd1);
    check({name, " hi"}, hi, expHi);
    check({name, " lo"}, lo, expLo);
    @(negedge clk);
    check({name, " doneSingle"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{OP_MULT,  32'd3,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[7]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[12] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 3'b0; srca = '0; srcb = '0;
    repeat (2) @(negedge clk);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    reset = 1'b0;

    // MTHI / MTLO complete in one cycle without busy or done.
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; srca = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mthi busy", {31'b0, busy}, 32'd0);
    check("mthi done", {31'b0, done}, 32'd0);
    start = 1'b1; op = OP_MTLO; srca = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h5678);
    check("mtlo hi", hi, 32'h1234);

    // Reserved op, start+abort together, and abort while idle are all ignored.
    start = 1'b1; op = OP_RSVD; srca = 32'hAAAA;
    @(negedge clk);
    start = 1'b0;
    check("rsvd busy", {31'b0, busy}, 32'd0);
    check("rsvd hi", hi, 32'h1234);
    start = 1'b1; abort = 1'b1; op = OP_MTHI; srca = 32'hBBBB;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("startAbort busy", {31'b0, busy}, 32'd0);
    check("startAbort hi", hi, 32'h1234);

    for (int i = 0; i < 13; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].expHi, vecs[i].expLo, 0);
    end

    // A start while busy must not disturb the op in flight.
    runOp("startWhileBusy", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5);

    // Abort on RUN cycle 10: idle next cycle, HI/LO unchanged, no done.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; srca = 32'd1000; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort busyBefore", {31'b0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd12);
    repeat (40) @(negedge clk);
    check("abort noLateDone", {31'b0, done}, 32'd0);
    check("abort loLate", lo, 32'd12);

    // Async reset in the middle of a DIV.
    runOp("preReset", OP_MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 0);
    start = 1'b1; op = OP_DIV; srca = 32'd100; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midReset busyBefore", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midReset hi", hi, 32'h0);
    check("midReset lo", lo, 32'h0);
    check("midReset busy", {31'b0, busy}, 32'd0);
    check("midReset done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    runOp("postReset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
